mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
//
// Shares a single-outstanding-read memory port between NUM_CH requesters.
// A request seen in IDLE is granted (round-robin or fixed priority), its
// address is latched and presented to memory for the whole WAIT phase, and
// the returned data (or an all-ones word with err set, when the optional
// watchdog fires) is handed back with a one-cycle finish pulse in DONE.
//
// Parameters
//   NUM_CH   number of requesting channels (2..8)
//   ADDR_W   address width
//   DATA_W   data width
//   RR_MODE  1 = round-robin, 0 = fixed priority (lowest index wins)
//   TIMEOUT  watchdog length in WAIT cycles, 0 disables the watchdog
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   req        per-channel level request, held until that channel's finish
//   addr       per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   finish     one-cycle completion pulse to the granted channel
//   rdata      returned data, valid while any finish bit is high
//   err        watchdog error flag, valid with finish
//   grant_id   index of the channel currently or most recently served
//   busy       high in every state except IDLE
//   mem_read   memory read request (high for every WAIT cycle)
//   mem_addr   memory address, stable while mem_read is high
//   mem_arrive one-cycle memory data-valid pulse
//   mem_data   memory read data, sampled with mem_arrive
// -----------------------------------------------------------------------------
module mem_read_arbiter #(
   parameter  int NUM_CH  = 2,
   parameter  int ADDR_W  = 64,
   parameter  int DATA_W  = 64,
   parameter  int RR_MODE = 1,
   parameter  int TIMEOUT = 0,
   localparam int GID_W   = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   output logic [NUM_CH-1:0]        finish,
   output logic [DATA_W-1:0]        rdata,
   output logic                     err,
   output logic [GID_W-1:0]         grant_id,
   output logic                     busy,
   output logic                     mem_read,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_arrive,
   input  logic [DATA_W-1:0]        mem_data
);

   // The watchdog counter must be able to hold TIMEOUT itself; keep at least
   // one bit so the design still elaborates when the watchdog is disabled.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [GID_W-1:0]    last_grant;
   logic [GID_W-1:0]    winner;
   logic                found;
   logic [CNT_W-1:0]    wait_cnt;
   logic                expire;

   // Winner selection. In round-robin mode the scan starts just after the
   // channel served last and wraps around; in fixed-priority mode it always
   // starts at channel 0, so last_grant has no influence.
   always_comb begin
      int idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (RR_MODE != 0) begin
            idx = (int'(last_grant) + 1 + k) % NUM_CH;
         end else begin
            idx = k;
         end
         if (!found && req[idx]) begin
            winner = GID_W'(idx);
            found  = 1'b1;
         end
      end
   end

   // Watchdog expires in the WAIT cycle whose count is TIMEOUT-1, i.e. after
   // exactly TIMEOUT cycles of mem_read without a response.
   assign expire = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the state-decoded outputs. mem_read and finish are
   // pure decodes of the state so they cannot outlive the phase they belong to,
   // which also guarantees at most one read is ever outstanding.
   always_comb begin
      state_next = state;
      mem_read   = 1'b0;
      busy       = 1'b1;
      finish     = '0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (found) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            mem_read = 1'b1;
            if (mem_arrive || expire) begin
               state_next = DONE;
            end
         end
         DONE: begin
            finish[grant_id] = 1'b1;
            state_next       = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers. The grant and address are captured only on the IDLE
   // to WAIT transition, so req/addr activity in WAIT and DONE is ignored.
   // Data arriving in the expiry cycle takes precedence over the watchdog.
   // mem_arrive outside WAIT is ignored, leaving rdata untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_id   <= '0;
         last_grant <= GID_W'(NUM_CH - 1);
         mem_addr   <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= winner;
                  mem_addr <= addr[int'(winner)*ADDR_W +: ADDR_W];
                  wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (mem_arrive) begin
                  rdata <= mem_data;
                  err   <= 1'b0;
               end else if (expire) begin
                  rdata <= '1;
                  err   <= 1'b1;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               last_grant <= grant_id;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_read_arbiter
//
// Two arbiters (round-robin and fixed-priority, both with a 5-cycle watchdog)
// share every input, so their state sequences stay in lockstep and only the
// grant choice differs. Expected grants, addresses, data and flags come from
// a transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [AW-1:0]   a [N];
   logic [N*AW-1:0] addr_bus;
   logic            mem_arrive;
   logic [DW-1:0]   mem_data;

   logic [N-1:0]    rr_finish,   fp_finish;
   logic [DW-1:0]   rr_rdata,    fp_rdata;
   logic            rr_err,      fp_err;
   logic [1:0]      rr_grant_id, fp_grant_id;
   logic            rr_busy,     fp_busy;
   logic            rr_mem_read, fp_mem_read;
   logic [AW-1:0]   rr_mem_addr, fp_mem_addr;

   int              tests  = 0;
   int              failed = 0;
   int              last_rr;
   logic [AW-1:0]   exp_addr_rr, exp_addr_fp;
   logic [DW-1:0]   exp_rdata;
   logic            exp_err;

   always #5 clk = ~clk;

   assign addr_bus = {a[3], a[2], a[1], a[0]};

   mem_read_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)) dut_rr (
      .clk(clk), .rst(rst), .req(req), .addr(addr_bus),
      .finish(rr_finish), .rdata(rr_rdata), .err(rr_err), .grant_id(rr_grant_id),
      .busy(rr_busy), .mem_read(rr_mem_read), .mem_addr(rr_mem_addr),
      .mem_arrive(mem_arrive), .mem_data(mem_data)
   );

   mem_read_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO)) dut_fp (
      .clk(clk), .rst(rst), .req(req), .addr(addr_bus),
      .finish(fp_finish), .rdata(fp_rdata), .err(fp_err), .grant_id(fp_grant_id),
      .busy(fp_busy), .mem_read(fp_mem_read), .mem_addr(fp_mem_addr),
      .mem_arrive(mem_arrive), .mem_data(mem_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin: the active channel at the smallest forward distance after
   // the last served channel wins.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      int best;
      int best_d;
      best   = -1;
      best_d = N;
      for (int ch = 0; ch < N; ch++) begin
         if (r[ch] && (((ch - last - 1 + N) % N) < best_d)) begin
            best_d = (ch - last - 1 + N) % N;
            best   = ch;
         end
      end
      return best;
   endfunction

   // Fixed priority: lowest set bit.
   function automatic int fp_pick(input logic [N-1:0] r);
      int best;
      best = -1;
      for (int ch = N - 1; ch >= 0; ch--) begin
         if (r[ch]) best = ch;
      end
      return best;
   endfunction

   // One full transaction, entered and left at #1 after a rising edge with
   // both arbiters idle. arr is the 1-based WAIT cycle in which memory
   // answers; any value outside 1..TO means memory never answers.
   task automatic run_txn(input logic [N-1:0] r, input int arr,
                          input logic [DW-1:0] dv, input bit rand_addr);
      int  wr;
      int  wf;
      int  c;
      bit  done;
      if (rand_addr) begin
         for (int i = 0; i < N; i++) a[i] = $urandom;
      end
      req = r;
      wr  = rr_pick(r, last_rr);
      wf  = fp_pick(r);
      exp_addr_rr = a[wr];
      exp_addr_fp = a[wf];
      @(posedge clk); #1;
      check("rr_grant_id", rr_grant_id, wr);
      check("fp_grant_id", fp_grant_id, wf);
      c    = 1;
      done = 1'b0;
      while (!done) begin
         check("rr_mem_read", rr_mem_read, 1);
         check("rr_mem_addr", rr_mem_addr, exp_addr_rr);
         check("fp_mem_addr", fp_mem_addr, exp_addr_fp);
         if (c == arr) begin
            mem_arrive = 1'b1;
            mem_data   = dv;
         end
         req = N'($urandom);
         for (int i = 0; i < N; i++) a[i] = $urandom;
         @(posedge clk); #1;
         mem_arrive = 1'b0;
         if (c == arr) begin
            exp_rdata = dv;
            exp_err   = 1'b0;
            done      = 1'b1;
         end else if (c == TO) begin
            exp_rdata = '1;
            exp_err   = 1'b1;
            done      = 1'b1;
         end
         c++;
      end
      check("rr_finish", rr_finish, 1 << wr);
      check("fp_finish", fp_finish, 1 << wf);
      check("rr_rdata", rr_rdata, exp_rdata);
      check("fp_rdata", fp_rdata, exp_rdata);
      check("rr_err", rr_err, exp_err);
      check("fp_err", fp_err, exp_err);
      check("done_mem_read", rr_mem_read, 0);
      check("done_busy", rr_busy, 1);
      req = '0;
      @(posedge clk); #1;
      check("idle_finish", rr_finish, 0);
      check("idle_busy", rr_busy, 0);
      check("idle_rdata_hold", rr_rdata, exp_rdata);
      check("idle_err_hold", fp_err, exp_err);
      last_rr = wr;
   endtask

   initial begin
      logic [DW-1:0] junk;
      rst        = 1'b0;
      req        = '0;
      mem_arrive = 1'b0;
      mem_data   = '0;
      for (int i = 0; i < N; i++) a[i] = '0;
      exp_rdata  = '0;
      exp_err    = 1'b0;
      last_rr    = N - 1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", rr_busy, 0);
      check("rst_mem_read", rr_mem_read, 0);
      check("rst_mem_addr", rr_mem_addr, 0);
      check("rst_finish", rr_finish, 0);
      check("rst_rdata", rr_rdata, 0);
      check("rst_err", rr_err, 0);
      check("rst_grant_id", rr_grant_id, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // All channels requesting: round-robin order 0,1,2,3,0
      run_txn(4'b1111, 1, $urandom, 1'b1);
      run_txn(4'b1111, 2, $urandom, 1'b1);
      run_txn(4'b1111, 3, $urandom, 1'b1);
      run_txn(4'b1111, 1, $urandom, 1'b1);
      run_txn(4'b1111, 2, $urandom, 1'b1);

      // Single requester on channel 1, memory answers 3 cycles after mem_read
      a[0] = 32'h1234_5678; a[1] = 32'h8000_0000; a[2] = 32'h0; a[3] = 32'h0;
      run_txn(4'b0010, 4, 32'h0000_0013, 1'b0);

      // Channels 1 and 2 requesting: fixed priority keeps serving channel 1
      run_txn(4'b0110, 1, $urandom, 1'b1);
      run_txn(4'b0110, 2, $urandom, 1'b1);
      run_txn(4'b0110, 1, $urandom, 1'b1);

      // Watchdog expiry, then data arriving exactly on the expiry cycle
      run_txn(4'b1000, 0, $urandom, 1'b1);
      run_txn(4'b0001, TO, $urandom, 1'b1);

      // Address change and stray mem_arrive while idle are ignored
      a[0]       = ~a[0];
      mem_arrive = 1'b1;
      mem_data   = ~exp_rdata;
      @(posedge clk); #1;
      mem_arrive = 1'b0;
      check("idle_ign_mem_addr", rr_mem_addr, exp_addr_rr);
      check("idle_ign_rdata", rr_rdata, exp_rdata);
      check("idle_ign_finish", rr_finish, 0);
      check("idle_ign_busy", rr_busy, 0);

      // Reset in the middle of WAIT, then a late mem_arrive
      req = 4'b0100;
      @(posedge clk); #1;
      check("pre_rst_busy", rr_busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_busy", rr_busy, 0);
      check("midrst_mem_read", rr_mem_read, 0);
      check("midrst_finish", rr_finish, 0);
      check("midrst_grant_id", rr_grant_id, 0);
      req = '0;
      @(posedge clk); #1;
      rst        = 1'b1;
      junk       = $urandom;
      mem_arrive = 1'b1;
      mem_data   = junk;
      @(posedge clk); #1;
      mem_arrive = 1'b0;
      check("late_arrive_finish", rr_finish | fp_finish, 0);
      check("late_arrive_busy", rr_busy, 0);
      check("late_arrive_rdata", rr_rdata, 0);
      @(posedge clk); #1;
      check("late_arrive_finish2", rr_finish, 0);
      last_rr   = N - 1;
      exp_rdata = '0;
      exp_err   = 1'b0;
      run_txn(4'b1111, 2, $urandom, 1'b1);

      // Randomized transactions; arr outside 1..TO forces a watchdog expiry
      for (int t = 0; t < 24; t++) begin
         run_txn(N'($urandom_range(1, 15)), $urandom_range(0, TO + 1), $urandom, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
